// File: rtl/unary_decoder_if.sv
// Handshake bundle between the unary stream producer, the decoder and the binary consumer.
interface unary_decoder_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic             in;
    logic             ready;
    logic [CNT_W-1:0] value;
    logic             valid;
    logic             overflow;
    logic             overrun;
    logic             busy;
    logic             err;

    modport master (
        output start, in, ready,
        input  value, valid, overflow, overrun, busy, err
    );

    modport slave (
        input  start, in, ready,
        output value, valid, overflow, overrun, busy, err
    );
endinterface

// File: rtl/unary_decoder.sv
// Converts one temporal-unary frame (contiguous run of 1s) into a saturating binary count.
// Optional macro UNARY_DECODER_STRICT_EN enables the sticky err flag for stray unary pulses.
//
// state | meaning
// IDLE  | waiting for start
// COUNT | accumulating the run of 1s
// HOLD  | result presented with valid=1 until valid&&ready
module unary_decoder #(
    parameter int BIN_BITS = 4,
    localparam int CNT_W = BIN_BITS + 2
) (
    input  logic            clk,
    input  logic            reset,
    unary_decoder_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << (BIN_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] value_q;
    logic             valid_q;
    logic             overflow_q;
    logic             overrun_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ovf        <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.in) begin
                            cnt   <= CNT_W'(1);
                            ovf   <= 1'b0;
                            state <= COUNT;
                        end else begin
                            value_q    <= '0;
                            overflow_q <= 1'b0;
                            valid_q    <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                COUNT: begin
                    if (bus.start)
                        overrun_q <= 1'b1;
                    if (bus.in) begin
                        // Saturate rather than wrap; ovf marks that ones were lost.
                        if (cnt == MAX_COUNT)
                            ovf <= 1'b1;
                        else
                            cnt <= cnt + 1'b1;
                    end else begin
                        value_q    <= cnt;
                        overflow_q <= ovf;
                        valid_q    <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        if (bus.start) begin
                            // Back-to-back frame: accepted as from IDLE in the transfer cycle.
                            if (bus.in) begin
                                cnt     <= CNT_W'(1);
                                ovf     <= 1'b0;
                                valid_q <= 1'b0;
                                state   <= COUNT;
                            end else begin
                                value_q    <= '0;
                                overflow_q <= 1'b0;
                            end
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (bus.start) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNARY_DECODER_STRICT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.in && ((state == IDLE && !bus.start) ||
                            (state == HOLD && !(bus.ready && bus.start))))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.value    = value_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_unary_decoder.sv
// Directed vector bench for unary_decoder: table of single-cycle vectors plus multi-cycle sequences.
module tb_unary_decoder;
    localparam int BIN_BITS = 4;
    localparam int CNT_W    = BIN_BITS + 2;
`ifdef UNARY_DECODER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        logic             rst;
        logic             start;
        logic             in_bit;
        logic             ready;
        logic             e_valid;
        logic [CNT_W-1:0] e_value;
        logic             e_ovf;
        logic             e_orun;
        logic             e_busy;
        logic             e_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    unary_decoder_if #(.CNT_W(CNT_W)) bus ();

    unary_decoder #(.BIN_BITS(BIN_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic s, input logic i, input logic r,
                                input logic v, input int val, input logic o, input logic orun,
                                input logic b, input logic e);
        vec_t t;
        t.rst = rst; t.start = s; t.in_bit = i; t.ready = r;
        t.e_valid = v; t.e_value = CNT_W'(val); t.e_ovf = o;
        t.e_orun = orun; t.e_busy = b; t.e_err = e;
        return t;
    endfunction

    task automatic chk(input string tag, input string field, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, field, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic s, input logic i, input logic r);
        reset     = rst;
        bus.start = s;
        bus.in    = i;
        bus.ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        drive(t.rst, t.start, t.in_bit, t.ready);
        chk(tag, "valid",    int'(bus.valid),    int'(t.e_valid));
        chk(tag, "value",    int'(bus.value),    int'(t.e_value));
        chk(tag, "overflow", int'(bus.overflow), int'(t.e_ovf));
        chk(tag, "overrun",  int'(bus.overrun),  int'(t.e_orun));
        chk(tag, "busy",     int'(bus.busy),     int'(t.e_busy));
        chk(tag, "err",      int'(bus.err),      int'(t.e_err));
    endtask

    vec_t tbl[13];

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.in = 1'b0; bus.ready = 1'b0;

        //             rst s  i  r   valid val ovf orun busy err
        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // reset state
        tbl[1]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // idle
        tbl[2]  = mk(0, 1, 1, 1,  0, 0, 0, 0, 1, 0);  // frame of 5: start with first one
        tbl[3]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1,  1, 5, 0, 0, 1, 0);  // first zero -> valid, value 5
        tbl[8]  = mk(0, 0, 0, 1,  0, 5, 0, 0, 0, 0);  // transferred -> valid drops
        tbl[9]  = mk(0, 1, 0, 1,  1, 0, 0, 0, 1, 0);  // zero frame
        tbl[10] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

        @(posedge clk); #1;
        for (int k = 0; k < 13; k++)
            run_vec(tbl[k], $sformatf("tbl%0d", k));

        // Saturation: start plus 35 ones then a zero
        drive(0, 1, 1, 1);
        for (int k = 0; k < 34; k++)
            drive(0, 0, 1, 1);
        chk("sat_run", "valid", int'(bus.valid), 0);
        run_vec(mk(0, 0, 0, 1,  1, 32, 1, 0, 1, 0), "sat_done");
        run_vec(mk(0, 0, 0, 1,  0, 32, 1, 0, 0, 0), "sat_xfer");

        // Back-to-back: result 7 held, then a frame of 2 started in the transfer cycle
        drive(0, 1, 1, 0);
        for (int k = 0; k < 6; k++)
            drive(0, 0, 1, 0);
        run_vec(mk(0, 0, 0, 0,  1, 7, 0, 0, 1, 0), "b2b_hold7");
        run_vec(mk(0, 0, 0, 0,  1, 7, 0, 0, 1, 0), "b2b_wait");
        run_vec(mk(0, 1, 1, 1,  0, 7, 0, 0, 1, 0), "b2b_start");
        run_vec(mk(0, 0, 1, 1,  0, 7, 0, 0, 1, 0), "b2b_one");
        run_vec(mk(0, 0, 0, 1,  1, 2, 0, 0, 1, 0), "b2b_res2");
        // zero-length frame back-to-back stays in HOLD with valid high
        run_vec(mk(0, 1, 0, 1,  1, 0, 0, 0, 1, 0), "b2b_zero");
        run_vec(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0), "b2b_idle");

        // Overrun: value 3 held with ready low, start pulsed in HOLD
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        run_vec(mk(0, 0, 0, 0,  1, 3, 0, 0, 1, 0), "orun_hold");
        run_vec(mk(0, 1, 0, 0,  1, 3, 0, 1, 1, 0), "orun_start");
        run_vec(mk(0, 0, 0, 0,  1, 3, 0, 1, 1, 0), "orun_keep1");
        run_vec(mk(0, 0, 0, 0,  1, 3, 0, 1, 1, 0), "orun_keep2");
        run_vec(mk(0, 0, 0, 1,  0, 3, 0, 1, 0, 0), "orun_xfer");
        run_vec(mk(0, 0, 0, 1,  0, 3, 0, 1, 0, 0), "orun_sticky");

        // Reset mid-COUNT after 4 ones, then a frame of 6
        drive(0, 1, 1, 1);
        for (int k = 0; k < 3; k++)
            drive(0, 0, 1, 1);
        run_vec(mk(1, 0, 1, 1,  0, 0, 0, 0, 0, 0), "rst_mid");
        run_vec(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0), "rst_idle");
        drive(0, 1, 1, 1);
        for (int k = 0; k < 5; k++)
            drive(0, 0, 1, 1);
        run_vec(mk(0, 0, 0, 1,  1, 6, 0, 0, 1, 0), "rst_frame6");
        run_vec(mk(0, 0, 0, 1,  0, 6, 0, 0, 0, 0), "rst_xfer");

        // Stray pulse after a frame of 3: err only in strict builds, sticky until reset
        drive(0, 1, 1, 1);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 1);
        run_vec(mk(0, 0, 0, 1,  1, 3, 0, 0, 1, 0), "err_frame3");
        run_vec(mk(0, 0, 0, 1,  0, 3, 0, 0, 0, 0), "err_xfer");
        run_vec(mk(0, 0, 1, 1,  0, 3, 0, 0, 0, STRICT), "err_stray");
        run_vec(mk(0, 0, 0, 1,  0, 3, 0, 0, 0, STRICT), "err_held1");
        run_vec(mk(0, 0, 0, 1,  0, 3, 0, 0, 0, STRICT), "err_held2");
        run_vec(mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 0), "err_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
